// File: rtl/dac_reg_ramp_pkg.sv
// Shared definitions for the DAC register/ramp block and the serial DAC stage.
package dac_reg_ramp_pkg;

  localparam int NUM_DAC_CH    = 4;
  localparam int DAC_CODE_W    = 8;
  localparam int DAC_REGDATA_W = NUM_DAC_CH * DAC_CODE_W;
  localparam int DAC_CHAN_W    = $clog2(NUM_DAC_CH);

  typedef logic [DAC_CODE_W-1:0] dac_code_t;
  typedef logic [DAC_CHAN_W-1:0] dac_chan_t;

  // Slew direction is never stored; it is always re-derived from cur vs tgt.
  typedef enum logic [1:0] {
    SLEW_IDLE = 2'd0,
    SLEW_UP   = 2'd1,
    SLEW_DOWN = 2'd2
  } slew_dir_e;

  // Control state: one cycle of INIT after reset before writes/ramping start.
  typedef enum logic {
    CTRL_INIT = 1'b0,
    CTRL_RUN  = 1'b1
  } ctrl_state_e;

  // Channel ch occupies DAC_regdata[dac_slice_lsb(ch) +: DAC_CODE_W].
  // The serial stage uses the same mapping to pick channels back out.
  function automatic int dac_slice_lsb(input int ch);
    return ch * DAC_CODE_W;
  endfunction

  // Direction the current code has to move to reach the target.
  function automatic slew_dir_e slew_dir(input dac_code_t cur, input dac_code_t tgt);
    if (cur < tgt) begin
      return SLEW_UP;
    end else if (cur > tgt) begin
      return SLEW_DOWN;
    end
    return SLEW_IDLE;
  endfunction

endpackage

// File: rtl/dac_slew_channel.sv
// One DAC channel: target/current code pair with rate-limited slewing.
module dac_slew_channel
  import dac_reg_ramp_pkg::*;
#(
  parameter int        MAX_STEP  = 1,
  parameter dac_code_t INIT_CODE = 8'h00
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      tick,
  input  logic      wr_en,
  input  dac_code_t wr_value,
  input  logic      wr_immediate,
  output dac_code_t cur,
  output logic      busy
);

  localparam logic [DAC_CODE_W:0]   MAX_STEP_WIDE = (DAC_CODE_W + 1)'(MAX_STEP);
  localparam logic [DAC_CODE_W-1:0] MAX_STEP_CODE = DAC_CODE_W'(MAX_STEP);

  dac_code_t           cur_reg;
  dac_code_t           cur_next;
  dac_code_t           tgt_reg;
  dac_code_t           tgt_next;
  logic                busy_reg;
  slew_dir_e           dir;
  logic [DAC_CODE_W:0] gap;       // one extra bit so the distance never wraps
  dac_code_t           step_amt;

  // Next cur/tgt: a write takes priority over a tick; otherwise step toward target.
  always_comb begin
    dir      = slew_dir(cur_reg, tgt_reg);
    gap      = '0;
    cur_next = cur_reg;
    tgt_next = tgt_reg;

    case (dir)
      SLEW_UP:   gap = {1'b0, tgt_reg} - {1'b0, cur_reg};
      SLEW_DOWN: gap = {1'b0, cur_reg} - {1'b0, tgt_reg};
      default:   gap = '0;
    endcase

    // Clipping the step to the remaining distance prevents overshoot and wrap.
    step_amt = (gap > MAX_STEP_WIDE) ? MAX_STEP_CODE : gap[DAC_CODE_W-1:0];

    if (wr_en) begin
      tgt_next = wr_value;
      if (wr_immediate) begin
        cur_next = wr_value;
      end
    end else if (tick) begin
      case (dir)
        SLEW_UP:   cur_next = cur_reg + step_amt;
        SLEW_DOWN: cur_next = cur_reg - step_amt;
        default:   cur_next = cur_reg;
      endcase
    end
  end

  // Code registers; busy is computed from the next values so it lines up with cur.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_reg  <= INIT_CODE;
      tgt_reg  <= INIT_CODE;
      busy_reg <= 1'b0;
    end else begin
      cur_reg  <= cur_next;
      tgt_reg  <= tgt_next;
      busy_reg <= (cur_next != tgt_next);
    end
  end

  assign cur  = cur_reg;
  assign busy = busy_reg;

endmodule

// File: rtl/dac_reg_ramp.sv
// Four-channel DAC code register with programmable slew, feeding DAC_regdata.
module dac_reg_ramp
  import dac_reg_ramp_pkg::*;
#(
  parameter int        STEP_DIV  = 4096,
  parameter int        MAX_STEP  = 1,
  parameter dac_code_t INIT_CODE = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DAC_CHAN_W-1:0]    in_chan,
  input  logic [DAC_CODE_W-1:0]    in_value,
  input  logic                     in_immediate,
  output logic [DAC_REGDATA_W-1:0] DAC_regdata,
  output logic [NUM_DAC_CH-1:0]    busy,
  output logic                     settled
);

  localparam int              PRESC_W   = $clog2(STEP_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

  ctrl_state_e          state_reg;
  ctrl_state_e          state_next;
  logic [PRESC_W-1:0]   presc_reg;
  logic [PRESC_W-1:0]   presc_next;
  logic                 tick;
  logic                 wr_fire;
  logic [NUM_DAC_CH-1:0] wr_en;
  dac_code_t            cur [NUM_DAC_CH];

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CTRL_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // INIT lasts exactly one cycle; writes are only accepted in RUN.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    case (state_reg)
      CTRL_INIT: state_next = CTRL_RUN;
      CTRL_RUN:  in_ready   = 1'b1;
      default:   state_next = CTRL_INIT;
    endcase
  end

  // Prescaler next value: parked at 0 in INIT, free-running wrap in RUN.
  always_comb begin
    tick       = (state_reg == CTRL_RUN) && (presc_reg == PRESC_LAST);
    presc_next = '0;
    if (state_reg == CTRL_RUN && !tick) begin
      presc_next = presc_reg + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end

  assign wr_fire = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < NUM_DAC_CH; gi++) begin : g_ch
      assign wr_en[gi] = wr_fire && (in_chan == DAC_CHAN_W'(gi));

      dac_slew_channel #(
        .MAX_STEP  (MAX_STEP),
        .INIT_CODE (INIT_CODE)
      ) u_ch (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .wr_en        (wr_en[gi]),
        .wr_value     (in_value),
        .wr_immediate (in_immediate),
        .cur          (cur[gi]),
        .busy         (busy[gi])
      );

      // cur is a channel register, so the output word carries no extra logic.
      assign DAC_regdata[dac_slice_lsb(gi) +: DAC_CODE_W] = cur[gi];
    end
  endgenerate

  // Derived from the registered busy bits, so it changes on the same edge.
  assign settled = ~|busy;

endmodule

// File: tb/tb_dac_reg_ramp.sv
// Self-checking bench for dac_reg_ramp (STEP_DIV=4, MAX_STEP=4 and MAX_STEP=255).
module tb_dac_reg_ramp;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_immediate, settled;
  logic [1:0]  in_chan;
  logic [7:0]  in_value;
  logic [31:0] dac;
  logic [3:0]  busy;

  logic        rst2, in_valid2, in_ready2, in_immediate2, settled2;
  logic [1:0]  in_chan2;
  logic [7:0]  in_value2;
  logic [31:0] dac2;
  logic [3:0]  busy2;

  always #5 clk = ~clk;

  dac_reg_ramp #(.STEP_DIV(4), .MAX_STEP(4), .INIT_CODE(8'h00)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_chan(in_chan), .in_value(in_value), .in_immediate(in_immediate),
    .DAC_regdata(dac), .busy(busy), .settled(settled)
  );

  dac_reg_ramp #(.STEP_DIV(4), .MAX_STEP(255), .INIT_CODE(8'h00)) dut2 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_chan(in_chan2), .in_value(in_value2), .in_immediate(in_immediate2),
    .DAC_regdata(dac2), .busy(busy2), .settled(settled2)
  );

  int checks = 0;
  int errors = 0;
  int ph = 0;   // prescaler phase of dut after the last edge; tick cycle is ph==3

  typedef struct {
    int         ch;
    logic [7:0] v;
    logic       imm;
    logic [31:0] exp_data;
    logic [3:0]  exp_busy;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  b;
  } exp_t;

  vec_t tbl [8];
  exp_t sb [$];

  task automatic tick_clk();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int ch);
    return d[ch*8 +: 8];
  endfunction

  task automatic drive_wr(input int ch, input logic [7:0] v, input logic imm);
    in_valid     = 1'b1;
    in_chan      = 2'(ch);
    in_value     = v;
    in_immediate = imm;
    tick_clk();
    in_valid     = 1'b0;
    in_immediate = 1'b0;
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < 4 && ph != p; i++) tick_clk();
  endtask

  task automatic release_reset();
    rst = 1'b1;
    tick_clk();
    tick_clk();
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst data", dac, 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst settled", 32'(settled), 32'd1);
    rst = 1'b0;
    chk("init in_ready", 32'(in_ready), 32'd0);
    tick_clk();
    ph = 0;
    chk("run in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp0, exp1, exp3, d;

    rst = 1'b1; in_valid = 1'b0; in_chan = 2'd0; in_value = 8'h00; in_immediate = 1'b0;
    rst2 = 1'b1; in_valid2 = 1'b0; in_chan2 = 2'd0; in_value2 = 8'h00; in_immediate2 = 1'b0;

    tbl[0] = '{0, 8'hAA, 1'b1, 32'h000000AA, 4'b0000};
    tbl[1] = '{3, 8'h55, 1'b1, 32'h550000AA, 4'b0000};
    tbl[2] = '{1, 8'hFF, 1'b1, 32'h5500FFAA, 4'b0000};
    tbl[3] = '{2, 8'h01, 1'b1, 32'h5501FFAA, 4'b0000};
    tbl[4] = '{0, 8'h00, 1'b1, 32'h5501FF00, 4'b0000};
    tbl[5] = '{1, 8'hFF, 1'b1, 32'h5501FF00, 4'b0000};
    tbl[6] = '{2, 8'h01, 1'b0, 32'h5501FF00, 4'b0000};
    tbl[7] = '{0, 8'h08, 1'b0, 32'h5501FF00, 4'b0001};

    // Reset release and table of immediate / equal-value writes
    release_reset();
    chk("run data", dac, 32'h0);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.d = tbl[i].exp_data;
      e.b = tbl[i].exp_busy;
      sb.push_back(e);
      drive_wr(tbl[i].ch, tbl[i].v, tbl[i].imm);
      e = sb.pop_front();
      chk($sformatf("tbl%0d data", i), dac, e.d);
      chk($sformatf("tbl%0d busy", i), 32'(busy), 32'(e.b));
    end

    // Ramp ch1 00 -> 10 in steps of 4, one step per tick
    release_reset();
    drive_wr(1, 8'h10, 1'b0);
    chk("ch1 wr busy", 32'(busy), 32'b0010);
    chk("ch1 wr code", 32'(byte_of(dac, 1)), 32'h00);
    chk("ch1 wr settled", 32'(settled), 32'd0);
    exp1 = 8'h00;
    for (int k = 1; k <= 4; k++) begin
      wait_ph(3);
      chk("ch1 pre-tick", 32'(byte_of(dac, 1)), 32'(exp1));
      tick_clk();
      exp1 = exp1 + 8'h04;
      chk("ch1 tick", 32'(byte_of(dac, 1)), 32'(exp1));
      chk("ch1 busy", 32'(busy), (exp1 == 8'h10) ? 32'b0000 : 32'b0010);
      chk("ch1 settled", 32'(settled), (exp1 == 8'h10) ? 32'd1 : 32'd0);
    end

    // ch2 immediate FE, then ramp down to 01 with clipped final step
    drive_wr(2, 8'hFE, 1'b1);
    chk("ch2 imm code", 32'(byte_of(dac, 2)), 32'hFE);
    chk("ch2 imm busy", 32'(busy), 32'b0000);
    drive_wr(2, 8'h01, 1'b0);
    chk("ch2 down busy", 32'(busy), 32'b0100);
    chk("ch2 down code", 32'(byte_of(dac, 2)), 32'hFE);
    exp1 = 8'hFE;
    for (int t = 0; t < 80 && exp1 != 8'h01; t++) begin
      wait_ph(3);
      tick_clk();
      d = exp1 - 8'h01;
      exp1 = exp1 - ((d > 8'h04) ? 8'h04 : d);
      chk("ch2 down step", 32'(byte_of(dac, 2)), 32'(exp1));
    end
    for (int i = 0; i < 8; i++) tick_clk();
    chk("ch2 floor code", 32'(byte_of(dac, 2)), 32'h01);
    chk("ch2 floor busy", 32'(busy), 32'b0000);

    // Write on ch0 in the exact tick cycle; ch3 ramps alongside
    wait_ph(0);
    drive_wr(0, 8'h20, 1'b0);
    drive_wr(3, 8'h30, 1'b0);
    wait_ph(3);
    tick_clk();
    chk("ch0 first step", 32'(byte_of(dac, 0)), 32'h04);
    chk("ch3 first step", 32'(byte_of(dac, 3)), 32'h04);
    wait_ph(3);
    drive_wr(0, 8'h07, 1'b0);
    chk("ch0 collide hold", 32'(byte_of(dac, 0)), 32'h04);
    chk("ch3 collide step", 32'(byte_of(dac, 3)), 32'h08);
    chk("collide busy", 32'(busy), 32'b1001);
    wait_ph(3);
    tick_clk();
    chk("ch0 clipped", 32'(byte_of(dac, 0)), 32'h07);
    chk("ch3 step", 32'(byte_of(dac, 3)), 32'h0C);
    chk("ch0 done busy", 32'(busy), 32'b1000);
    exp3 = 8'h0C;
    for (int t = 0; t < 20 && exp3 != 8'h30; t++) begin
      wait_ph(3);
      tick_clk();
      exp3 = exp3 + 8'h04;
      chk("ch3 ramp", 32'(byte_of(dac, 3)), 32'(exp3));
    end
    chk("all settled", 32'(settled), 32'd1);
    chk("all codes", dac, 32'h30011007);

    // Reset pulse mid-ramp on ch1 (cur=08, tgt=10)
    drive_wr(1, 8'h00, 1'b1);
    drive_wr(1, 8'h10, 1'b0);
    exp0 = 8'h00;
    for (int k = 0; k < 2; k++) begin
      wait_ph(3);
      tick_clk();
      exp0 = exp0 + 8'h04;
    end
    chk("mid ramp codes", dac, {24'h300100, 8'h07} | (32'(exp0) << 8));
    chk("mid ramp busy", 32'(busy), 32'b0010);
    rst = 1'b1;
    tick_clk();
    chk("mid rst data", dac, 32'h0);
    chk("mid rst busy", 32'(busy), 32'h0);
    chk("mid rst settled", 32'(settled), 32'd1);
    chk("mid rst ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    chk("mid init ready", 32'(in_ready), 32'd0);
    tick_clk();
    ph = 0;
    chk("mid run ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 12; i++) tick_clk();
    chk("post rst data", dac, 32'h0);
    chk("post rst busy", 32'(busy), 32'h0);

    // MAX_STEP=255: full-scale jump in one tick, no wrap
    rst2 = 1'b1;
    tick_clk();
    tick_clk();
    rst2 = 1'b0;
    chk("big init ready", 32'(in_ready2), 32'd0);
    tick_clk();
    chk("big run ready", 32'(in_ready2), 32'd1);
    in_valid2 = 1'b1; in_chan2 = 2'd3; in_value2 = 8'hFF; in_immediate2 = 1'b0;
    tick_clk();
    in_valid2 = 1'b0;
    chk("big wr data", dac2, 32'h0);
    chk("big wr busy", 32'(busy2), 32'b1000);
    tick_clk();
    tick_clk();
    chk("big pre-tick", dac2, 32'h0);
    tick_clk();
    chk("big tick data", dac2, 32'hFF000000);
    chk("big tick busy", 32'(busy2), 32'b0000);
    chk("big settled", 32'(settled2), 32'd1);
    for (int i = 0; i < 8; i++) tick_clk();
    chk("big no wrap", dac2, 32'hFF000000);
    in_valid2 = 1'b1; in_chan2 = 2'd3; in_value2 = 8'h00; in_immediate2 = 1'b0;
    tick_clk();
    in_valid2 = 1'b0;
    for (int i = 0; i < 3; i++) tick_clk();
    chk("big down data", dac2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
